// File: rtl/tick_pkg.sv
// Shared limits, state encoding and schedule field layout for the tick divider
// and its schedule sequencer.
package tick_pkg;

  localparam int SEL_W       = 2;
  localparam int CNT_W       = 6;
  localparam int SEL_OFS     = 0;
  localparam int REP_OFS     = SEL_W;
  localparam int DEF_NB_REP  = 8;
  localparam int DEF_N_STEPS = 4;

  localparam logic [CNT_W-1:0] R0 = 6'd10;
  localparam logic [CNT_W-1:0] R1 = 6'd20;
  localparam logic [CNT_W-1:0] R2 = 6'd30;
  localparam logic [CNT_W-1:0] R3 = 6'd40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sel_limit(input logic [SEL_W-1:0] sel);
    case (sel)
      2'd0:    return R0;
      2'd1:    return R1;
      2'd2:    return R2;
      default: return R3;
    endcase
  endfunction

endpackage

// File: rtl/tick_div.sv
// Selectable-limit divider: counts enabled cycles 0..L and strobes on the wrap.
module tick_div
  import tick_pkg::*;
(
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_tick
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] limit;
  logic             terminal;

  assign limit    = sel_limit(i_sel);
  assign terminal = (count_reg >= limit);

  // Combinational strobe so the sequencer can advance on the same edge the count wraps.
  assign o_tick = i_enable && !i_clear && terminal;

  always_comb begin
    count_next = count_reg;
    if (i_clear) begin
      count_next = '0;
    end else if (i_enable) begin
      count_next = terminal ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Runs the tick divider through a latched schedule of (sel, repeat) steps,
// producing one strobe per divider tick plus busy/done status.
module tick_sequencer
  import tick_pkg::*;
#(
  parameter int NB_REP  = DEF_NB_REP,
  parameter int N_STEPS = DEF_N_STEPS
) (
  input  logic                              clock,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic                              i_hold,
  input  logic [N_STEPS*(SEL_W+NB_REP)-1:0] i_sched,
  output logic [SEL_W-1:0]                  o_sel,
  output logic [1:0]                        o_step,
  output logic                              o_tick,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int         FIELD_W   = SEL_W + NB_REP;
  localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

  state_t                     state_reg, state_next;
  logic [N_STEPS*FIELD_W-1:0] sched_reg, sched_next;
  logic [1:0]                 step_reg, step_next;
  logic [NB_REP-1:0]          rep_cnt_reg, rep_cnt_next;
  logic                       tick_reg, tick_next;

  logic [SEL_W-1:0]  step_sel [N_STEPS];
  logic [NB_REP-1:0] step_rep [N_STEPS];
  logic [SEL_W-1:0]  cur_sel;
  logic [NB_REP-1:0] cur_rep;
  logic              rep_zero;
  logic              rep_last;
  logic              last_step;
  logic              div_enable;
  logic              div_clear;
  logic              div_tick;

  generate
    for (genvar gi = 0; gi < N_STEPS; gi++) begin : g_field
      assign step_sel[gi] = sched_reg[gi*FIELD_W + SEL_OFS +: SEL_W];
      assign step_rep[gi] = sched_reg[gi*FIELD_W + REP_OFS +: NB_REP];
    end
  endgenerate

  assign cur_sel   = step_sel[step_reg];
  assign cur_rep   = step_rep[step_reg];
  assign rep_zero  = (cur_rep == '0);
  assign rep_last  = (rep_cnt_reg == cur_rep - NB_REP'(1));
  assign last_step = (step_reg == LAST_STEP);

  assign div_enable = (state_reg == RUN) && !rep_zero && !i_hold && !i_abort;
  assign div_clear  = i_abort || ((state_reg == IDLE) && i_start);

  tick_div u_div (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_clear  (div_clear),
    .i_enable (div_enable),
    .i_sel    (cur_sel),
    .o_tick   (div_tick)
  );

  always_comb begin
    state_next   = state_reg;
    sched_next   = sched_reg;
    step_next    = step_reg;
    rep_cnt_next = rep_cnt_reg;
    tick_next    = div_tick;

    if (i_abort) begin
      state_next   = IDLE;
      step_next    = '0;
      rep_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            sched_next   = i_sched;
            step_next    = '0;
            rep_cnt_next = '0;
            state_next   = RUN;
          end
        end
        RUN: begin
          // Hold freezes the step pointer and repeat count along with the divider.
          if (!i_hold && (rep_zero || (div_tick && rep_last))) begin
            rep_cnt_next = '0;
            if (last_step) begin
              state_next = DONE;
            end else begin
              step_next = step_reg + 1'b1;
            end
          end else if (!i_hold && div_tick) begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_next = IDLE;
          step_next  = '0;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= IDLE;
      sched_reg   <= '0;
      step_reg    <= '0;
      rep_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sched_reg   <= sched_next;
      step_reg    <= step_next;
      rep_cnt_reg <= rep_cnt_next;
      tick_reg    <= tick_next;
    end
  end

  assign o_sel  = (state_reg == IDLE) ? '0 : cur_sel;
  assign o_step = step_reg;
  assign o_tick = tick_reg;
  assign o_busy = (state_reg == RUN);
  assign o_done = (state_reg == DONE);

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer: directed table, corner sequences and
// randomized schedules against a step/period reference model.
module tb_tick_sequencer;

  localparam int NB_REP  = 8;
  localparam int N_STEPS = 4;
  localparam int FW      = 2 + NB_REP;
  localparam int SW      = N_STEPS * FW;
  localparam int MAXC    = 2048;

  logic          clock   = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_hold  = 1'b0;
  logic [SW-1:0] i_sched = '0;
  logic [1:0]    o_sel;
  logic [1:0]    o_step;
  logic          o_tick;
  logic          o_busy;
  logic          o_done;

  tick_sequencer #(.NB_REP(NB_REP), .N_STEPS(N_STEPS)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_abort (i_abort),
    .i_hold  (i_hold),
    .i_sched (i_sched),
    .o_sel   (o_sel),
    .o_step  (o_step),
    .o_tick  (o_tick),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic       hold_arr  [MAXC];
  logic       start_arr [MAXC];
  logic       scramble;
  logic       obs_tick  [MAXC];
  logic       obs_done  [MAXC];
  logic       obs_busy  [MAXC];
  logic [1:0] obs_step  [MAXC];
  logic [1:0] obs_sel   [MAXC];
  bit         exp_tick  [MAXC];
  bit         exp_done  [MAXC];
  bit         exp_busy  [MAXC];
  int         exp_step  [MAXC];
  int         exp_sel   [MAXC];
  int         rnd_sel   [4];
  int         rnd_rep   [4];

  typedef struct {
    logic [SW-1:0] sched;
    int            hold_at;
    int            hold_len;
    int            first_tick;
    int            last_tick;
    int            done_at;
    int            n_ticks;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [SW-1:0] mk_sched(input int s0, input int r0, input int s1, input int r1,
                                             input int s2, input int r2, input int s3, input int r3);
    logic [SW-1:0] v;
    int s [4];
    int r [4];
    s = '{s0, s1, s2, s3};
    r = '{r0, r1, r2, r3};
    v = '0;
    for (int k = 0; k < 4; k++) begin
      v[k*FW +: 2]      = 2'(s[k]);
      v[k*FW + 2 +: 8]  = 8'(r[k]);
    end
    return v;
  endfunction

  function automatic int lim(input int sel);
    return 10 * (sel + 1);
  endfunction

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [SW-1:0] s);
    i_sched = s;
    i_start = 1'b1;
    next_cycle();
    i_start = 1'b0;
  endtask

  // Cycle t is the interval following edge E0+t; inputs driven in cycle t are sampled at E0+t+1.
  task automatic capture(input logic [SW-1:0] s, output int t_done);
    t_done = -1;
    launch(s);
    for (int t = 0; t < MAXC; t++) begin
      obs_tick[t] = o_tick;
      obs_done[t] = o_done;
      obs_busy[t] = o_busy;
      obs_step[t] = o_step;
      obs_sel[t]  = o_sel;
      if (o_done && t_done < 0) t_done = t;
      if (t_done >= 0 && t >= t_done + 2) break;
      i_hold  = hold_arr[t];
      i_start = start_arr[t];
      if (scramble) i_sched = SW'({$urandom(), $urandom()});
      next_cycle();
    end
    i_hold  = 1'b0;
    i_start = 1'b0;
    i_sched = s;
    check("done_within_bound", t_done >= 0, 1);
  endtask

  // Reference: step k with rep>0 needs rep*(L+1) enabled cycles, ticking at every (L+1)th.
  task automatic model(output int t_end);
    int t;
    int need;
    int en;
    for (int k = 0; k < MAXC; k++) begin
      exp_tick[k] = 0; exp_done[k] = 0; exp_busy[k] = 0; exp_step[k] = 0; exp_sel[k] = 0;
    end
    t = 0;
    for (int s = 0; s < 4; s++) begin
      if (rnd_rep[s] == 0) begin
        exp_busy[t] = 1; exp_step[t] = s; exp_sel[t] = rnd_sel[s];
        t++;
      end else begin
        need = rnd_rep[s] * (lim(rnd_sel[s]) + 1);
        en   = 0;
        while (en < need && t < MAXC - 4) begin
          exp_busy[t] = 1; exp_step[t] = s; exp_sel[t] = rnd_sel[s];
          if (!hold_arr[t]) begin
            en++;
            if (en % (lim(rnd_sel[s]) + 1) == 0) exp_tick[t+1] = 1;
          end
          t++;
        end
      end
    end
    exp_done[t] = 1;
    t_end = t;
  endtask

  initial begin
    int td;
    int first;
    int last;
    int cnt;
    int dcnt;
    int t_end;
    int e0;
    bit any_zero;
    logic [SW-1:0] s;

    // Reset state
    #12;
    check("rst_tick", o_tick, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_sel", o_sel, 0);
    check("rst_step", o_step, 0);
    @(negedge clock);
    i_reset = 1'b1;
    next_cycle();
    check("idle_busy", o_busy, 0);

    // Directed table
    vecs[0] = '{mk_sched(0,2, 1,1, 2,0, 3,1), -1, 0, 11, 85, 85, 4};
    vecs[1] = '{mk_sched(1,0, 2,0, 3,0, 0,0), -1, 0, -1, -1, 4, 0};
    vecs[2] = '{mk_sched(3,1, 3,0, 3,0, 3,0), -1, 0, 41, 41, 44, 1};
    vecs[3] = '{mk_sched(0,1, 0,1, 0,1, 0,1), -1, 0, 11, 44, 44, 4};
    vecs[4] = '{mk_sched(2,0, 1,0, 0,0, 3,3), -1, 0, 44, 126, 126, 3};
    vecs[5] = '{mk_sched(1,3, 0,0, 0,0, 0,0), -1, 0, 21, 63, 66, 3};
    vecs[6] = '{mk_sched(0,1, 0,0, 0,0, 0,0), 3, 5, 16, 16, 19, 1};
    vecs[7] = '{mk_sched(0,2, 1,1, 2,0, 3,1), 30, 10, 11, 95, 95, 4};

    scramble = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < MAXC; k++) begin
        hold_arr[k]  = (vecs[v].hold_at >= 0) && (k >= vecs[v].hold_at) &&
                       (k < vecs[v].hold_at + vecs[v].hold_len);
        start_arr[k] = 1'b0;
      end
      capture(vecs[v].sched, td);
      first = -1; last = -1; cnt = 0; dcnt = 0;
      for (int k = 0; k <= td + 2 && td >= 0; k++) begin
        if (obs_tick[k]) begin
          if (first < 0) first = k;
          last = k;
          cnt++;
        end
        if (obs_done[k]) dcnt++;
      end
      check($sformatf("v%0d_first_tick", v), first, vecs[v].first_tick);
      check($sformatf("v%0d_last_tick", v), last, vecs[v].last_tick);
      check($sformatf("v%0d_done_at", v), td, vecs[v].done_at);
      check($sformatf("v%0d_n_ticks", v), cnt, vecs[v].n_ticks);
      check($sformatf("v%0d_done_pulses", v), dcnt, 1);
      check($sformatf("v%0d_busy_c0", v), obs_busy[0], 1);
      if (td >= 0) begin
        check($sformatf("v%0d_busy_at_done", v), obs_busy[td], 0);
        check($sformatf("v%0d_busy_after", v), obs_busy[td+1], 0);
      end
      $display("vector %0d: done_at=%0d ticks=%0d first=%0d last=%0d", v, td, cnt, first, last);
    end

    // All rep=0 with i_start pulses during RUN, then start in DONE and one cycle later
    launch(mk_sched(1,0, 2,0, 3,0, 0,0));
    for (int t = 0; t < 4; t++) begin
      check($sformatf("zero_step_c%0d", t), o_step, t);
      check($sformatf("zero_busy_c%0d", t), o_busy, 1);
      check($sformatf("zero_tick_c%0d", t), o_tick, 0);
      i_start = 1'b1;
      next_cycle();
    end
    check("zero_done_c4", o_done, 1);
    check("zero_busy_c4", o_busy, 0);
    next_cycle();
    check("start_in_done_ignored", o_busy, 0);
    check("idle_after_done", o_done, 0);
    next_cycle();
    i_start = 1'b0;
    check("start_after_done_accepted", o_busy, 1);
    check("restart_step", o_step, 0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_done) break;
      next_cycle();
      cnt++;
    end
    check("restart_done_latency", cnt, 4);
    next_cycle();
    $display("sequence zero_rep: restart done after %0d cycles", cnt);

    // i_start and i_abort together in IDLE
    i_sched = mk_sched(0,1, 0,1, 0,1, 0,1);
    i_start = 1'b1;
    i_abort = 1'b1;
    next_cycle();
    i_start = 1'b0;
    i_abort = 1'b0;
    check("start_abort_busy", o_busy, 0);
    next_cycle();
    check("start_abort_busy2", o_busy, 0);
    check("start_abort_tick", o_tick, 0);
    $display("sequence start_with_abort: busy=%0d", o_busy);

    // Abort at E0+15, restart sampled at E0+17
    launch(mk_sched(0,5, 0,0, 0,0, 0,0));
    repeat (15) next_cycle();
    check("abort_busy_c15", o_busy, 1);
    i_abort = 1'b1;
    next_cycle();
    i_abort = 1'b0;
    check("abort_busy_c16", o_busy, 0);
    check("abort_done_c16", o_done, 0);
    check("abort_tick_c16", o_tick, 0);
    i_start = 1'b1;
    next_cycle();
    i_start = 1'b0;
    check("abort_restart_busy", o_busy, 1);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      next_cycle();
      if (o_tick) begin
        cnt = k;
        break;
      end
    end
    check("abort_restart_first_tick", cnt, 11);
    $display("sequence abort: restart first tick after %0d edges", cnt);
    i_abort = 1'b1;
    next_cycle();
    i_abort = 1'b0;

    // Asynchronous reset at tick 3 of a sel=11, rep=10 step
    launch(mk_sched(3,10, 0,0, 0,0, 0,0));
    cnt = 0;
    for (int k = 0; k < 500; k++) begin
      if (o_tick) cnt++;
      if (cnt == 3) break;
      next_cycle();
    end
    check("rst_mid_tick3_seen", cnt, 3);
    #2;
    i_reset = 1'b0;
    #1;
    check("rst_mid_tick", o_tick, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_done", o_done, 0);
    check("rst_mid_sel", o_sel, 0);
    check("rst_mid_step", o_step, 0);
    @(negedge clock);
    i_reset = 1'b1;
    cnt = 0;
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      if (o_tick) cnt++;
      if (o_busy) dcnt++;
    end
    check("post_rst_ticks", cnt, 0);
    check("post_rst_busy", dcnt, 0);
    $display("sequence reset_mid_run: ticks after release=%0d", cnt);

    // Randomized schedules with hold, stray starts and schedule edits during RUN
    for (int trial = 0; trial < 30; trial++) begin
      any_zero = 0;
      for (int k = 0; k < 4; k++) begin
        rnd_sel[k] = int'($urandom_range(0, 3));
        rnd_rep[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
        if (rnd_rep[k] == 0) any_zero = 1;
      end
      for (int k = 0; k < MAXC; k++) begin
        hold_arr[k]  = any_zero ? 1'b0 : ($urandom_range(0, 3) == 0);
        start_arr[k] = 1'b0;
      end
      model(t_end);
      for (int k = 0; k <= t_end; k++) start_arr[k] = ($urandom_range(0, 4) == 0);
      s = mk_sched(rnd_sel[0], rnd_rep[0], rnd_sel[1], rnd_rep[1],
                   rnd_sel[2], rnd_rep[2], rnd_sel[3], rnd_rep[3]);
      scramble = 1'b1;
      capture(s, td);
      scramble = 1'b0;
      check($sformatf("rnd%0d_done_at", trial), td, t_end);
      e0 = n_err;
      for (int k = 0; k <= t_end + 2; k++) begin
        check($sformatf("rnd%0d_tick_c%0d", trial, k), obs_tick[k], 32'(exp_tick[k]));
        check($sformatf("rnd%0d_done_c%0d", trial, k), obs_done[k], 32'(exp_done[k]));
        check($sformatf("rnd%0d_busy_c%0d", trial, k), obs_busy[k], 32'(exp_busy[k]));
        if (exp_busy[k]) begin
          check($sformatf("rnd%0d_step_c%0d", trial, k), obs_step[k], exp_step[k]);
          check($sformatf("rnd%0d_sel_c%0d", trial, k), obs_sel[k], exp_sel[k]);
        end
        if (n_err != e0) break;
      end
      $display("random %0d: reps=%0d/%0d/%0d/%0d sels=%0d/%0d/%0d/%0d done_at=%0d expected=%0d",
               trial, rnd_rep[0], rnd_rep[1], rnd_rep[2], rnd_rep[3],
               rnd_sel[0], rnd_sel[1], rnd_sel[2], rnd_sel[3], td, t_end);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
    $fatal(1);
  end

endmodule
